// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-port nvm_mem between the CPU (port c) and the debug/loader (port d):
// per-cycle round-robin, plus a debug lock mode that yields one cycle to the CPU every MAX_LOCK cycles.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_LOCK   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  c_req,
  input  logic                  c_we,
  input  logic [ADDR_WIDTH-1:0] c_addr,
  input  logic [DATA_WIDTH-1:0] c_wd,
  output logic                  c_gnt,
  output logic                  c_rvalid,
  output logic [DATA_WIDTH-1:0] c_rdata,
  input  logic                  d_req,
  input  logic                  d_lock,
  input  logic                  d_we,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wd,
  output logic                  d_gnt,
  output logic                  d_rvalid,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wd,
  input  logic [DATA_WIDTH-1:0] mem_rd,
  output logic                  locked,
  output logic [1:0]            dbg_state,
  output logic [7:0]            dbg_lock_cnt
);

  // Handshake: a transfer happens in any cycle where req and gnt are both high. gnt is
  // combinational from state, prio and req; requesters hold we/addr/wd stable while req is high.

  typedef enum logic [1:0] {
    ST_ARB    = 2'd0,
    ST_LOCKED = 2'd1,
    ST_YIELD  = 2'd2
  } state_t;

  localparam logic [7:0] LOCK_LAST = 8'(MAX_LOCK - 1);

  state_t     state, state_nxt;
  logic       prio, prio_nxt;
  logic [7:0] lock_cnt, lock_cnt_nxt;
  logic       c_rv_q, d_rv_q;

  // State register, including the read-return flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_ARB;
      prio     <= 1'b0;
      lock_cnt <= 8'd0;
      c_rv_q   <= 1'b0;
      d_rv_q   <= 1'b0;
    end else begin
      state    <= state_nxt;
      prio     <= prio_nxt;
      lock_cnt <= lock_cnt_nxt;
      c_rv_q   <= c_gnt & ~c_we;
      d_rv_q   <= d_gnt & ~d_we;
    end
  end

  // Next state. Leaving the lock always restarts round-robin with the CPU first.
  always_comb begin
    state_nxt    = state;
    prio_nxt     = prio;
    lock_cnt_nxt = lock_cnt;
    if (c_gnt || d_gnt) prio_nxt = c_gnt;
    case (state)
      ST_ARB: begin
        if (d_gnt && d_lock) begin
          state_nxt    = ST_LOCKED;
          lock_cnt_nxt = 8'd0;
        end
      end
      ST_LOCKED: begin
        lock_cnt_nxt = lock_cnt + 8'd1;
        if (!d_lock) begin
          state_nxt = ST_ARB;
          prio_nxt  = 1'b0;
        end else if (lock_cnt == LOCK_LAST) begin
          state_nxt = ST_YIELD;
        end
      end
      ST_YIELD: begin
        if (d_lock) begin
          state_nxt    = ST_LOCKED;
          lock_cnt_nxt = 8'd0;
        end else begin
          state_nxt = ST_ARB;
          prio_nxt  = 1'b0;
        end
      end
      default: begin
        state_nxt = ST_ARB;
        prio_nxt  = 1'b0;
      end
    endcase
  end

  // Outputs: grants, memory mux, read return.
  always_comb begin
    c_gnt = 1'b0;
    d_gnt = 1'b0;
    if (!rst) begin
      case (state)
        ST_ARB: begin
          if (c_req && d_req) begin
            c_gnt = ~prio;
            d_gnt = prio;
          end else begin
            c_gnt = c_req;
            d_gnt = d_req;
          end
        end
        ST_LOCKED: d_gnt = d_req;
        ST_YIELD: begin
          c_gnt = c_req;
          d_gnt = d_req & ~c_req;
        end
        default: ;
      endcase
    end

    mem_we   = 1'b0;
    mem_addr = '0;
    mem_wd   = '0;
    if (c_gnt) begin
      mem_we   = c_we;
      mem_addr = c_addr;
      mem_wd   = c_wd;
    end else if (d_gnt) begin
      mem_we   = d_we;
      mem_addr = d_addr;
      mem_wd   = d_wd;
    end

    c_rvalid     = c_rv_q & ~rst;
    d_rvalid     = d_rv_q & ~rst;
    c_rdata      = c_rvalid ? mem_rd : '0;
    d_rdata      = d_rvalid ? mem_rd : '0;
    locked       = (state != ST_ARB) & ~rst;
    dbg_state    = state;
    dbg_lock_cnt = lock_cnt;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with MAX_LOCK = 4 and a small registered-read memory model.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        c_req, c_we, c_gnt, c_rvalid;
  logic [31:0] c_addr, c_wd, c_rdata;
  logic        d_req, d_lock, d_we, d_gnt, d_rvalid;
  logic [31:0] d_addr, d_wd, d_rdata;
  logic        mem_we, locked;
  logic [31:0] mem_addr, mem_wd, mem_rd;
  logic [1:0]  dbg_state;
  logic [7:0]  dbg_lock_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] mem [0:255];

  // clock / reset
  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_LOCK(4)) dut (
    .clk(clk), .rst(rst),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wd(c_wd),
    .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
    .d_req(d_req), .d_lock(d_lock), .d_we(d_we), .d_addr(d_addr), .d_wd(d_wd),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_rd(mem_rd),
    .locked(locked), .dbg_state(dbg_state), .dbg_lock_cnt(dbg_lock_cnt)
  );

  // nvm_mem stand-in: registered read, preloaded while reset is held.
  always @(posedge clk) begin
    if (rst) begin
      mem[8'h10] <= 32'hDEADBEEF;
      mem[8'h20] <= 32'hCAFEF00D;
    end else if (mem_we) begin
      mem[mem_addr[7:0]] <= mem_wd;
    end
    mem_rd <= mem[mem_addr[7:0]];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic exp_c;
    rst = 1'b1;
    c_req = 1'b1; c_we = 1'b1; c_addr = 32'h10; c_wd = 32'h0;
    d_req = 1'b1; d_lock = 1'b0; d_we = 1'b1; d_addr = 32'h20; d_wd = 32'h0;

    // reset held two cycles with both requesting
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); #1;
      check("rst_c_gnt", c_gnt, 0);
      check("rst_d_gnt", d_gnt, 0);
      check("rst_mem_we", mem_we, 0);
      check("rst_c_rvalid", c_rvalid, 0);
      check("rst_d_rvalid", d_rvalid, 0);
      check("rst_locked", locked, 0);
    end

    // round-robin reads: c, d, c, d
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (k == 0) begin rst = 1'b0; c_we = 1'b0; d_we = 1'b0; end
      #1;
      check("rr_c_gnt", c_gnt, 32'((k % 2) == 0));
      check("rr_d_gnt", d_gnt, 32'((k % 2) == 1));
      check("rr_mem_addr", mem_addr, (k % 2 == 0) ? 32'h10 : 32'h20);
      check("rr_c_rvalid", c_rvalid, 32'((k % 2) == 1));
      check("rr_d_rvalid", d_rvalid, 32'(k > 0 && (k % 2) == 0));
      check("rr_c_rdata", c_rdata, (k % 2 == 1) ? 32'hDEADBEEF : 32'h0);
      check("rr_d_rdata", d_rdata, (k > 0 && k % 2 == 0) ? 32'hCAFEF00D : 32'h0);
    end
    @(negedge clk); c_req = 1'b0; d_req = 1'b0; #1;
    check("idle_c_gnt", c_gnt, 0);
    check("idle_d_gnt", d_gnt, 0);
    check("idle_mem_addr", mem_addr, 0);
    check("rr_last_d_rvalid", d_rvalid, 1);
    check("rr_last_d_rdata", d_rdata, 32'hCAFEF00D);
    check("rr_last_c_rvalid", c_rvalid, 0);

    // debug write, then CPU read back
    @(negedge clk); d_req = 1'b1; d_we = 1'b1; d_addr = 32'h40; d_wd = 32'h12345678; #1;
    check("wr_d_gnt", d_gnt, 1);
    check("wr_c_gnt", c_gnt, 0);
    check("wr_mem_we", mem_we, 1);
    check("wr_mem_addr", mem_addr, 32'h40);
    check("wr_mem_wd", mem_wd, 32'h12345678);
    @(negedge clk); d_req = 1'b0; d_we = 1'b0; c_req = 1'b1; c_addr = 32'h40; #1;
    check("wr_no_d_rvalid", d_rvalid, 0);
    check("rd40_c_gnt", c_gnt, 1);
    check("rd40_mem_we", mem_we, 0);
    @(negedge clk); c_req = 1'b0; #1;
    check("rd40_c_rvalid", c_rvalid, 1);
    check("rd40_c_rdata", c_rdata, 32'h12345678);

    // enter lock, then both request continuously
    @(negedge clk); d_req = 1'b1; d_lock = 1'b1; d_addr = 32'h20; #1;
    check("lk_entry_d_gnt", d_gnt, 1);
    check("lk_entry_locked", locked, 0);
    c_addr = 32'h10;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (k == 0) c_req = 1'b1;
      #1;
      exp_c = (k == 4) || (k == 9);
      check("lk_c_gnt", c_gnt, 32'(exp_c));
      check("lk_d_gnt", d_gnt, 32'(!exp_c));
      check("lk_locked", locked, 1);
      check("lk_state", dbg_state, exp_c ? 32'd2 : 32'd1);
      if (!exp_c) check("lk_cnt", dbg_lock_cnt, (k < 4) ? k : k - 5);
    end

    // release: last locked cycle still favours debug, then ARB with CPU first
    @(negedge clk); d_lock = 1'b0; #1;
    check("rel_d_gnt", d_gnt, 1);
    check("rel_c_gnt", c_gnt, 0);
    check("rel_locked", locked, 1);
    @(negedge clk); #1;
    check("rel_arb_c_gnt", c_gnt, 1);
    check("rel_arb_d_gnt", d_gnt, 0);
    check("rel_arb_locked", locked, 0);
    check("rel_arb_state", dbg_state, 0);

    // reset while locked with a debug read in flight
    @(negedge clk); c_req = 1'b0; d_lock = 1'b1; #1;
    check("rml_entry_d_gnt", d_gnt, 1);
    @(negedge clk); #1;
    check("rml_locked", locked, 1);
    check("rml_read_d_gnt", d_gnt, 1);
    @(negedge clk); rst = 1'b1; #1;
    check("rml_rst_d_gnt", d_gnt, 0);
    check("rml_rst_d_rvalid", d_rvalid, 0);
    check("rml_rst_mem_we", mem_we, 0);
    @(negedge clk); rst = 1'b0; d_req = 1'b0; d_lock = 1'b0; #1;
    check("rml_post_d_rvalid", d_rvalid, 0);
    check("rml_post_locked", locked, 0);
    check("rml_post_state", dbg_state, 0);
    check("rml_post_cnt", dbg_lock_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
